// File: rtl/coord_sequencer.sv
// Raster scheduler for coord_control: walks a COLS x ROWS view, pulses frame/row/load strobes,
// hands points to the iteration engine, and applies queued host config writes between frames.
module coord_sequencer #(
    parameter int COLS   = 320,
    parameter int ROWS   = 240,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     demo_en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [2:0]               cfg_sel,
    input  logic [12:0]              cfg_value,
    output logic [2:0]               ctrl,
    output logic [12:0]              value,
    output logic                     next_frame,
    output logic                     next_row,
    output logic                     coord_load,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [$clog2(COLS)-1:0]  col,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic                     frame_done
);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int QAW = $clog2(QDEPTH);
    localparam logic [2:0] CTRL_DEMO = 3'b000;
    localparam logic [2:0] CTRL_NONE = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_FSTART,
        S_PRIME,
        S_PIXEL
    } state_t;

    state_t          r_state;
    logic            r_next_frame;
    logic            r_prime_row;
    logic            r_px_valid;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;

    logic [2:0]      r_q_sel [QDEPTH];
    logic [12:0]     r_q_val [QDEPTH];
    logic [QAW-1:0]  r_wr_ptr;
    logic [QAW-1:0]  r_rd_ptr;
    logic [QAW:0]    r_count;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [QAW:0]    w_count_next;
    logic            w_xfer;
    logic            w_col_last;
    logic            w_row_last;
    logic [2:0]      w_head_sel;
    logic [12:0]     w_head_val;
    logic            w_head_keep;

    assign w_full      = (r_count == (QAW+1)'(QDEPTH));
    assign w_push      = cfg_valid && !w_full;
    assign w_pop       = (r_state == S_CFG);
    assign w_xfer      = (r_state == S_PIXEL) && px_ready;
    assign w_col_last  = (r_col == CW'(COLS - 1));
    assign w_row_last  = (r_row == RW'(ROWS - 1));
    assign w_head_sel  = r_q_sel[r_rd_ptr];
    assign w_head_val  = r_q_val[r_rd_ptr];
    assign w_head_keep = (w_head_sel != CTRL_DEMO) && (w_head_sel != CTRL_NONE);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + (QAW+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - (QAW+1)'(1);
        end
    end

    // Queue storage carries no reset; only the pointers and occupancy define its contents.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_qslot
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == QAW'(gi))) begin
                    r_q_sel[gi] <= cfg_sel;
                    r_q_val[gi] <= cfg_value;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + QAW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + QAW'(1);
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_next_frame <= 1'b0;
            r_prime_row  <= 1'b0;
            r_px_valid   <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
        end else begin
            r_next_frame <= 1'b0;
            r_prime_row  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_CFG;
                    end else if (run) begin
                        r_state      <= S_FSTART;
                        r_next_frame <= 1'b1;
                    end
                end
                S_CFG: begin
                    // Writes pushed while draining keep us here until the queue is truly empty.
                    if (w_count_next == '0) begin
                        if (run) begin
                            r_state      <= S_FSTART;
                            r_next_frame <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FSTART: begin
                    r_state     <= S_PRIME;
                    r_prime_row <= 1'b1;
                    r_col       <= '0;
                    r_row       <= '0;
                end
                S_PRIME: begin
                    r_state    <= S_PIXEL;
                    r_px_valid <= 1'b1;
                end
                S_PIXEL: begin
                    if (px_ready) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row      <= '0;
                                r_px_valid <= 1'b0;
                                if (r_count != '0) begin
                                    r_state <= S_CFG;
                                end else if (run) begin
                                    r_state      <= S_FSTART;
                                    r_next_frame <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_row <= r_row + RW'(1);
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Transfer-time strobes must follow px_ready in the same cycle to sustain one point per clock.
    assign cfg_ready  = !w_full;
    assign next_frame = r_next_frame;
    assign px_valid   = r_px_valid;
    assign coord_load = r_next_frame || (w_xfer && !(w_col_last && w_row_last));
    assign next_row   = r_prime_row || (w_xfer && w_col_last && !w_row_last);
    assign frame_done = w_xfer && w_col_last && w_row_last;
    assign col        = r_col;
    assign row        = r_row;

    always_comb begin
        ctrl  = CTRL_NONE;
        value = '0;
        if (w_pop && w_head_keep) begin
            ctrl  = w_head_sel;
            value = w_head_val;
        end else if (r_next_frame && demo_en) begin
            ctrl = CTRL_DEMO;
        end
    end

endmodule

// File: tb/tb_coord_sequencer.sv
// Randomized bench for coord_sequencer on a 4x3 raster, compared cycle by cycle against a
// pixel-index / queue reference model of the scheduling rules.
module tb_coord_sequencer;
    localparam int COLS   = 4;
    localparam int ROWS   = 3;
    localparam int QDEPTH = 4;
    localparam int NPIX   = COLS * ROWS;
    localparam int P_IDLE = 0, P_CFG = 1, P_FSTART = 2, P_PRIME = 3, P_PIXEL = 4;

    logic        clk = 1'b0;
    logic        rst, run, demo_en, cfg_valid, cfg_ready, px_ready;
    logic [2:0]  cfg_sel, ctrl;
    logic [12:0] cfg_value, value;
    logic        next_frame, next_row, coord_load, px_valid, frame_done;
    logic [1:0]  col, row;

    always #5 clk = ~clk;

    coord_sequencer #(.COLS(COLS), .ROWS(ROWS), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .run(run), .demo_en(demo_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_value(cfg_value),
        .ctrl(ctrl), .value(value), .next_frame(next_frame), .next_row(next_row),
        .coord_load(coord_load), .px_valid(px_valid), .px_ready(px_ready),
        .col(col), .row(row), .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_obs    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: phase, pixel index within frame, pending config writes.
    int          m_phase = P_IDLE;
    int          m_pix   = 0;
    logic [15:0] m_q[$];

    // Pending host write, held until the model says it was accepted.
    logic        h_cv  = 1'b0;
    logic [2:0]  h_sel = 3'b0;
    logic [12:0] h_val = 13'b0;

    task automatic step(input logic s_run, input logic s_demo, input logic s_cv,
                        input logic [2:0] s_sel, input logic [12:0] s_val,
                        input logic s_rdy, input logic s_rst, output logic acc);
        logic [2:0]  e_ctrl;
        logic [12:0] e_val;
        logic [5:0]  e_flags;
        logic        xfer, last, push;
        int          size0;
        rst = s_rst; run = s_run; demo_en = s_demo; cfg_valid = s_cv;
        cfg_sel = s_sel; cfg_value = s_val; px_ready = s_rdy;
        #3;
        size0  = m_q.size();
        e_ctrl = 3'b011;
        e_val  = '0;
        if (m_phase == P_CFG && m_q[0][15:13] != 3'b000 && m_q[0][15:13] != 3'b011) begin
            e_ctrl = m_q[0][15:13];
            e_val  = m_q[0][12:0];
        end
        if (m_phase == P_FSTART && s_demo) e_ctrl = 3'b000;
        xfer = (m_phase == P_PIXEL) && s_rdy;
        last = (m_pix == NPIX - 1);
        e_flags = {m_phase == P_FSTART,
                   (m_phase == P_PRIME) || (xfer && (m_pix % COLS == COLS - 1) && !last),
                   (m_phase == P_FSTART) || (xfer && !last),
                   m_phase == P_PIXEL,
                   xfer && last,
                   size0 < QDEPTH};
        check_val("ctrl_value", {16'b0, ctrl, value}, {16'b0, e_ctrl, e_val});
        check_val("flags", {26'b0, next_frame, next_row, coord_load, px_valid, frame_done, cfg_ready},
                  {26'b0, e_flags});
        check_val("col_row", {28'b0, row, col},
                  (m_phase == P_PIXEL) ? 32'((m_pix / COLS) * 4 + (m_pix % COLS)) : 32'd0);
        if (px_valid && px_ready) n_obs++;
        if (frame_done) begin
            check_val("frame_pixels", n_obs, NPIX);
            n_obs = 0;
        end
        push = s_cv && (size0 < QDEPTH) && !s_rst;
        acc  = push;
        if (s_rst) begin
            m_phase = P_IDLE; m_pix = 0; m_q.delete(); n_obs = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (size0 > 0) m_phase = P_CFG;
                    else if (s_run) m_phase = P_FSTART;
                end
                P_CFG: begin
                    void'(m_q.pop_front());
                    if (push) m_q.push_back({s_sel, s_val});
                    push = 1'b0;
                    if (m_q.size() == 0) m_phase = s_run ? P_FSTART : P_IDLE;
                end
                P_FSTART: begin m_phase = P_PRIME; m_pix = 0; end
                P_PRIME:  m_phase = P_PIXEL;
                default: begin
                    if (s_rdy) begin
                        if (last) m_phase = (size0 > 0) ? P_CFG : (s_run ? P_FSTART : P_IDLE);
                        else m_pix++;
                    end
                end
            endcase
            if (push) m_q.push_back({s_sel, s_val});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int n, input int run_pct, input logic demo,
                            input int cv_pct, input int rdy_pct, input int rst_pm);
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (!h_cv && ($urandom % 100) < cv_pct) begin
                h_cv = 1'b1; h_sel = 3'($urandom); h_val = 13'($urandom);
            end
            step(($urandom % 100) < run_pct, demo, h_cv, h_sel, h_val,
                 ($urandom % 100) < rdy_pct, ($urandom % 1000) < rst_pm, acc);
            if (acc) h_cv = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   sels[6];
        sels = '{1, 3, 2, 5, 4, 6};
        rst = 1'b1; run = 1'b0; demo_en = 1'b0; cfg_valid = 1'b0;
        cfg_sel = '0; cfg_value = '0; px_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Full-rate frames, then a randomly stalling engine.
        rand_run(40, 100, 1'b0, 0, 100, 0);
        rand_run(80, 100, 1'b0, 0, 50, 0);
        // Three writes pushed mid-frame: applied only after the frame ends.
        rand_run(5, 100, 1'b0, 0, 100, 0);
        step(1, 0, 1, 3'b001, 13'h0123, 1, 0, acc);
        step(1, 0, 1, 3'b010, 13'h0456, 1, 0, acc);
        step(1, 0, 1, 3'b100, 13'h1789, 1, 0, acc);
        rand_run(30, 100, 1'b0, 0, 100, 0);
        // Overfill the queue with a held write, including a dropped sel 011.
        foreach (sels[k]) begin
            h_cv = 1'b1; h_sel = 3'(sels[k]); h_val = 13'($urandom);
            for (int t = 0; t < 200 && h_cv; t++) begin
                step(1, 0, h_cv, h_sel, h_val, ($urandom % 100) < 70, 0, acc);
                if (acc) h_cv = 1'b0;
            end
        end
        rand_run(40, 100, 1'b0, 0, 70, 0);
        // Demo frames, then run dropped mid-frame.
        rand_run(30, 100, 1'b1, 0, 80, 0);
        rand_run(40, 0, 1'b1, 0, 80, 0);
        // Reset mid-row with writes still queued.
        rand_run(8, 100, 1'b0, 0, 100, 0);
        step(1, 0, 1, 3'b101, 13'h0aaa, 1, 0, acc);
        step(1, 0, 1, 3'b110, 13'h0bbb, 1, 0, acc);
        step(1, 0, 0, 3'b000, 13'h0000, 1, 1, acc);
        rand_run(20, 0, 1'b0, 0, 100, 0);
        // Fully random traffic with occasional resets.
        rand_run(1500, 90, 1'b0, 30, 70, 3);
        rand_run(300, 90, 1'b1, 40, 60, 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
